// File: rtl/weight_col_mem_pkg.sv
// Shared definitions for the gate weight stores and their load controllers:
// Q-format word sizing, address sizing helper and the load FSM state type.
package weight_col_mem_pkg;

  localparam int DEF_NROW = 16;
  localparam int DEF_NCOL = 8;
  localparam int DEF_QN   = 6;
  localparam int DEF_QM   = 11;

  // Bits needed to index n entries, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int word_width(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic int column_width(input int qn, input int qm, input int nrow);
    return word_width(qn, qm) * nrow;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_t;

endpackage

// File: rtl/wcm_load_ctrl.sv
// Serial load sequencer: walks row/column counters column-major over the
// weight matrix and flags a complete, consistent matrix with mem_valid.
module wcm_load_ctrl
  import weight_col_mem_pkg::*;
#(
  parameter int NROW          = DEF_NROW,
  parameter int NCOL          = DEF_NCOL,
  parameter int ROW_BITWIDTH  = clog2_min1(NROW),
  parameter int ADDR_BITWIDTH = clog2_min1(NCOL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load_start,
  input  logic                     i_load_valid,
  output logic                     o_load_ready,
  output logic                     o_load_done,
  output logic                     o_mem_valid,
  output logic                     o_wr_en,
  output logic [ROW_BITWIDTH-1:0]  o_row,
  output logic [ADDR_BITWIDTH-1:0] o_col
);

  localparam logic [ROW_BITWIDTH-1:0]  ROW_LAST = ROW_BITWIDTH'(NROW - 1);
  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST = ADDR_BITWIDTH'(NCOL - 1);

  load_state_t              r_state;
  load_state_t              w_state_nxt;
  logic [ROW_BITWIDTH-1:0]  r_row;
  logic [ADDR_BITWIDTH-1:0] r_col;
  logic                     r_load_done;
  logic                     r_mem_valid;
  logic                     w_accept;
  logic                     w_last;

  // A restart pulse wins over any word presented in the same cycle.
  always_comb begin
    w_accept    = (r_state == LOAD) && i_load_valid && !i_load_start;
    w_last      = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (i_load_start) w_state_nxt = LOAD;
      LOAD: begin
        if (i_load_start)  w_state_nxt = LOAD;
        else if (w_last)   w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_load_done <= 1'b0;
      r_mem_valid <= 1'b0;
    end else begin
      r_load_done <= w_last;
      if (i_load_start) begin
        r_row       <= '0;
        r_col       <= '0;
        r_mem_valid <= 1'b0;
      end else if (w_accept) begin
        if (r_row == ROW_LAST) begin
          r_row <= '0;
          r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
        if (w_last) r_mem_valid <= 1'b1;
      end
    end
  end

  assign o_load_ready = (r_state == LOAD);
  assign o_load_done  = r_load_done;
  assign o_mem_valid  = r_mem_valid;
  assign o_wr_en      = w_accept;
  assign o_row        = r_row;
  assign o_col        = r_col;

endmodule

// File: rtl/weight_col_mem.sv
// Column-organised weight store: one registered NROW-word column per cycle
// for the requested address, filled column-major from a serial load port.
module weight_col_mem
  import weight_col_mem_pkg::*;
#(
  parameter int NROW           = DEF_NROW,
  parameter int NCOL           = DEF_NCOL,
  parameter int QN             = DEF_QN,
  parameter int QM             = DEF_QM,
  parameter int BITWIDTH       = word_width(QN, QM),
  parameter int LAYER_BITWIDTH = BITWIDTH * NROW,
  parameter int ADDR_BITWIDTH  = clog2_min1(NCOL)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic [BITWIDTH-1:0]       load_word,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic                      load_done,
  output logic                      mem_valid,
  input  logic [ADDR_BITWIDTH-1:0]  colAddress,
  output logic [LAYER_BITWIDTH-1:0] weightMem
);

  localparam int ROW_BITWIDTH = clog2_min1(NROW);

  logic [LAYER_BITWIDTH-1:0] r_mem [NCOL];
  logic [LAYER_BITWIDTH-1:0] r_weight;
  logic                      w_wr_en;
  logic [ROW_BITWIDTH-1:0]   w_row;
  logic [ADDR_BITWIDTH-1:0]  w_col;
  logic [NROW-1:0]           w_row_we;
  logic                      w_addr_ok;

  wcm_load_ctrl #(
    .NROW          (NROW),
    .NCOL          (NCOL),
    .ROW_BITWIDTH  (ROW_BITWIDTH),
    .ADDR_BITWIDTH (ADDR_BITWIDTH)
  ) u_load_ctrl (
    .clk          (clk),
    .reset        (reset),
    .i_load_start (load_start),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .o_load_done  (load_done),
    .o_mem_valid  (mem_valid),
    .o_wr_en      (w_wr_en),
    .o_row        (w_row),
    .o_col        (w_col)
  );

  always_comb begin
    w_row_we = '0;
    for (int r = 0; r < NROW; r++) begin
      w_row_we[r] = w_wr_en && (w_row == ROW_BITWIDTH'(r));
    end
  end

  // Storage is deliberately not reset; mem_valid tells consumers when it is usable.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NROW; r++) begin
      if (w_row_we[r]) r_mem[w_col][r*BITWIDTH +: BITWIDTH] <= load_word;
    end
  end

  generate
    if (NCOL == (1 << ADDR_BITWIDTH)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_range
      localparam logic [ADDR_BITWIDTH:0] NCOL_LIM = (ADDR_BITWIDTH + 1)'(NCOL);
      assign w_addr_ok = ({1'b0, colAddress} < NCOL_LIM);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_weight <= '0;
    else if (w_addr_ok) r_weight <= r_mem[colAddress];
    else                r_weight <= '0;
  end

  assign weightMem = r_weight;

endmodule

// File: tb/tb_weight_col_mem.sv
// Directed bench for weight_col_mem: loads, restarts, reset mid-load, read sweep.
module tb_weight_col_mem;

  localparam int NROW = 16;
  localparam int NCOL = 8;
  localparam int BW   = 18;
  localparam int LW   = BW * NROW;
  localparam int NW   = NROW * NCOL;

  logic          clk;
  logic          reset;
  logic          load_start;
  logic [BW-1:0] load_word;
  logic          load_valid;
  logic          load_ready;
  logic          load_done;
  logic          mem_valid;
  logic [2:0]    colAddress;
  logic [LW-1:0] weightMem;

  int n_pass;
  int n_total;

  weight_col_mem dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_word  (load_word),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_done  (load_done),
    .mem_valid  (mem_valid),
    .colAddress (colAddress),
    .weightMem  (weightMem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] exp_col(input int base, input int c);
    logic [LW-1:0] v;
    for (int r = 0; r < NROW; r++) v[r*BW +: BW] = BW'(base + c * NROW + r);
    return v;
  endfunction

  // Pulses load_start, then streams words base+k. done_j counts cycles from the
  // start edge to the observed load_done; limit < NW stops after that many words.
  task automatic run_load(input int base, input bit toggle, input bit neg, input int limit,
                          output int done_j, output int n_done, output bit mv_early);
    int k;
    k = 0; done_j = -1; n_done = 0; mv_early = 1'b0;
    @(negedge clk); load_start = 1'b1; load_valid = 1'b0;
    @(negedge clk); load_start = 1'b0;
    for (int j = 0; j < 400; j++) begin
      if (load_done) begin
        n_done++;
        if (done_j < 0) done_j = j;
      end
      if (mem_valid && done_j < 0) mv_early = 1'b1;
      if (done_j >= 0 && j >= done_j + 2) break;
      if (limit < NW && k >= limit) break;
      if (k < limit) begin
        load_valid = toggle ? (j % 2 == 1) : 1'b1;
        if (neg && k == 0)           load_word = 18'h3FFFF;
        else if (neg && k == NW - 1) load_word = 18'h20000;
        else                         load_word = BW'(base + k);
        if (load_valid) k++;
      end else begin
        load_valid = 1'b0;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (load_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", load_ready); else n_pass++;
    n_total++; if (load_done !== 1'b0) $display("FAIL reset_done: got %b want 0", load_done); else n_pass++;
    n_total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_valid); else n_pass++;
    n_total++; if (weightMem !== '0) $display("FAIL reset_weightMem: got %h want 0", weightMem); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    int dj, nd; bit me;
    run_load(1, 1'b0, 1'b0, NW, dj, nd, me);
    n_total++; if (dj !== 128) $display("FAIL full_done_cycle: got %0d want 128", dj); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL full_done_pulses: got %0d want 1", nd); else n_pass++;
    n_total++; if (me !== 1'b0) $display("FAIL full_mem_valid_early: got %b want 0", me); else n_pass++;
    n_total++; if (mem_valid !== 1'b1) $display("FAIL full_mem_valid: got %b want 1", mem_valid); else n_pass++;
    n_total++; if (load_ready !== 1'b0) $display("FAIL full_ready_after: got %b want 0", load_ready); else n_pass++;
    colAddress = 3'd3;
    @(negedge clk);
    n_total++; if (weightMem !== exp_col(1, 3)) $display("FAIL full_col3: got %h want %h", weightMem, exp_col(1, 3)); else n_pass++;
  endtask

  task automatic test_toggle_load();
    int dj, nd; bit me;
    run_load(1, 1'b1, 1'b0, NW, dj, nd, me);
    n_total++; if (dj !== 256) $display("FAIL toggle_done_cycle: got %0d want 256", dj); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL toggle_done_pulses: got %0d want 1", nd); else n_pass++;
    colAddress = 3'd3;
    @(negedge clk);
    n_total++; if (weightMem !== exp_col(1, 3)) $display("FAIL toggle_col3: got %h want %h", weightMem, exp_col(1, 3)); else n_pass++;
    colAddress = 3'd0;
    @(negedge clk);
    n_total++; if (weightMem !== exp_col(1, 0)) $display("FAIL toggle_col0: got %h want %h", weightMem, exp_col(1, 0)); else n_pass++;
  endtask

  task automatic test_negative();
    int dj, nd; bit me;
    run_load(1, 1'b0, 1'b1, NW, dj, nd, me);
    n_total++; if (dj !== 128) $display("FAIL neg_done_cycle: got %0d want 128", dj); else n_pass++;
    colAddress = 3'd0;
    @(negedge clk);
    n_total++; if (weightMem[0 +: BW] !== 18'h3FFFF) $display("FAIL neg_c0r0: got %h want 3ffff", weightMem[0 +: BW]); else n_pass++;
    n_total++; if (weightMem[BW +: BW] !== 18'd2) $display("FAIL neg_c0r1: got %h want 2", weightMem[BW +: BW]); else n_pass++;
    colAddress = 3'd7;
    @(negedge clk);
    n_total++; if (weightMem[15*BW +: BW] !== 18'h20000) $display("FAIL neg_c7r15: got %h want 20000", weightMem[15*BW +: BW]); else n_pass++;
    n_total++; if (weightMem[14*BW +: BW] !== 18'd127) $display("FAIL neg_c7r14: got %h want 7f", weightMem[14*BW +: BW]); else n_pass++;
  endtask

  task automatic test_restart();
    int dj, nd; bit me;
    run_load(1, 1'b0, 1'b0, 37, dj, nd, me);
    n_total++; if (nd !== 0) $display("FAIL restart_partial_done: got %0d want 0", nd); else n_pass++;
    n_total++; if (mem_valid !== 1'b0) $display("FAIL restart_partial_mem_valid: got %b want 0", mem_valid); else n_pass++;
    run_load(500, 1'b0, 1'b0, NW, dj, nd, me);
    n_total++; if (me !== 1'b0) $display("FAIL restart_mem_valid_early: got %b want 0", me); else n_pass++;
    n_total++; if (dj !== 128) $display("FAIL restart_done_cycle: got %0d want 128", dj); else n_pass++;
    colAddress = 3'd0;
    @(negedge clk);
    n_total++; if (weightMem !== exp_col(500, 0)) $display("FAIL restart_col0: got %h want %h", weightMem, exp_col(500, 0)); else n_pass++;
    // Final word presented together with load_start must be discarded.
    run_load(700, 1'b0, 1'b0, NW - 1, dj, nd, me);
    load_start = 1'b1; load_valid = 1'b1; load_word = 18'd999; colAddress = 3'd7;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b0;
    n_total++; if (mem_valid !== 1'b0) $display("FAIL collide_mem_valid: got %b want 0", mem_valid); else n_pass++;
    n_total++; if (load_done !== 1'b0) $display("FAIL collide_done: got %b want 0", load_done); else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL collide_ready: got %b want 1", load_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (weightMem[15*BW +: BW] !== 18'd627) $display("FAIL collide_c7r15: got %0d want 627", weightMem[15*BW +: BW]); else n_pass++;
    n_total++; if (weightMem[14*BW +: BW] !== 18'd826) $display("FAIL collide_c7r14: got %0d want 826", weightMem[14*BW +: BW]); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int dj, nd; bit me;
    colAddress = 3'd0;
    run_load(1, 1'b0, 1'b0, 60, dj, nd, me);
    #2 reset = 1'b1;
    #1;
    n_total++; if (load_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", load_ready); else n_pass++;
    n_total++; if (mem_valid !== 1'b0) $display("FAIL midrst_mem_valid: got %b want 0", mem_valid); else n_pass++;
    n_total++; if (load_done !== 1'b0) $display("FAIL midrst_done: got %b want 0", load_done); else n_pass++;
    n_total++; if (weightMem !== '0) $display("FAIL midrst_weightMem: got %h want 0", weightMem); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    run_load(1000, 1'b0, 1'b0, NW, dj, nd, me);
    n_total++; if (dj !== 128) $display("FAIL midrst_reload_done: got %0d want 128", dj); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL midrst_reload_pulses: got %0d want 1", nd); else n_pass++;
    n_total++; if (mem_valid !== 1'b1) $display("FAIL midrst_reload_mem_valid: got %b want 1", mem_valid); else n_pass++;
  endtask

  task automatic test_read_sweep();
    for (int i = 0; i <= NCOL; i++) begin
      if (i > 0) begin
        n_total++;
        if (weightMem !== exp_col(1000, i - 1))
          $display("FAIL sweep_col%0d: got %h want %h", i - 1, weightMem, exp_col(1000, i - 1));
        else n_pass++;
      end
      if (i < NCOL) colAddress = 3'(i);
      @(negedge clk);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; load_start = 1'b0; load_word = '0; load_valid = 1'b0; colAddress = '0;
    test_reset();
    test_full_load();
    test_toggle_load();
    test_negative();
    test_restart();
    test_reset_mid_load();
    test_read_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/weight_col_mem.md
# weight_col_mem

Column-organised weight store that answers column-address requests from the gate dot-product engines. Each cycle it returns one full weight column, NROW signed fixed-point words, for the address presented. It is filled beforehand from a serial word stream through a valid/ready load port. One instance sits beside each dot-product unit in a gate: one for the input-side matrix and one for the recurrent-side matrix.

## Interface
Parameters:
- NROW, 16: words per column (hidden size).
- NCOL, 8: number of columns (input size, or hidden size for the recurrent instance).
- QN, 6: integer bits of the Q format.
- QM, 11: fractional bits of the Q format.
- BITWIDTH, QN+QM+1: derived word width.
- LAYER_BITWIDTH, BITWIDTH*NROW: derived column width.
- ADDR_BITWIDTH, clog2(NCOL), minimum 1: derived address width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- load_start  in  1  one-cycle pulse; begins or restarts a full load.
- load_word  in  BITWIDTH  signed weight word.
- load_valid  in  1  load_word is valid this cycle.
- load_ready  out  1  block accepts a word; reset 0.
- load_done  out  1  one-cycle pulse after the final word; reset 0.
- mem_valid  out  1  level; storage holds a complete, consistent matrix; reset 0.
- colAddress  in  ADDR_BITWIDTH  column requested by the dot-product engine.
- weightMem  out  LAYER_BITWIDTH  registered column data; reset 0.

## Operation
- Load FSM has two states: IDLE and LOAD.
  - IDLE: load_ready=0. load_start moves to LOAD, clears the word counter, and drops mem_valid.
  - LOAD: load_ready=1. A word is accepted when load_valid and load_ready are both high.
- Word k (k = 0 … NROW*NCOL-1) is stored column-major:
  - column = k / NROW, row = k mod NROW.
  - Row r occupies bits [r*BITWIDTH +: BITWIDTH] of the column.
- Counters: a row counter wraps at NROW-1 and increments a column counter. Acceptance at row=NROW-1, column=NCOL-1 is the final word.
- Final word accepted: next state is IDLE, mem_valid←1, and load_done pulses.
- load_start while in LOAD restarts the load. Counters clear, mem_valid stays 0, and any word presented in that same cycle is discarded. load_start has priority over a simultaneous final word.
- load_valid while in IDLE is ignored.
- Read path, every cycle: weightMem ← storage[colAddress]. The read is independent of FSM state.
  - During LOAD the data is partially stale. Consumers gate their start on mem_valid.
  - A colAddress ≥ NCOL (when NCOL is not a power of 2) returns all zeros.
- Same-cycle write and read of the same column returns the pre-write contents (read-before-write).
- Words are stored bit-exact; there is no sign-extension or saturation.
- Reset clears the FSM, counters, weightMem, load_done and mem_valid. The storage array is not cleared. Reset mid-load leaves a partial matrix with mem_valid=0.

## Timing
- Read latency is 1 cycle: colAddress sampled at edge t appears on weightMem after edge t. Back-to-back addresses give one column per cycle.
- load_start at edge t: load_ready=1 from cycle t+1.
- Load throughput is 1 word/cycle; a full load takes NROW*NCOL accepting cycles minimum.
- Final word accepted at edge t: after edge t, load_ready=0, mem_valid=1, and load_done=1 for exactly that cycle.
- A word written at edge t is readable by a colAddress sampled at edge t+1 and appears on weightMem after edge t+1.

## Structure
- The shared package holds:
  - BITWIDTH and LAYER_BITWIDTH derivation from QN/QM/NROW.
  - A clog2 helper.
  - The FSM state enum {IDLE, LOAD}, shared with the other gate-level load controllers.
- One sub-module, wcm_load_ctrl, contains the FSM, row/column counters, load_ready, load_done and mem_valid. It outputs a write enable, row index and column index.
- The top level contains:
  - the storage array, with per-row write enables inside the column;
  - the registered read mux.

## Test plan
- Full load with defaults, load_word = k+1 for word k, load_valid held high; then colAddress=3. Expected: weightMem row r = 49+r; load_done a single pulse 128 cycles after load_ready rises; mem_valid=1.
- load_valid toggled 1/0 every cycle during the load. Expected: only accepted words are stored; load_done 256 cycles after start; contents identical to the first test.
- Negative words: row 0 of column 0 = 18'h3FFFF (-1), row 15 of column 7 = 18'h20000. Expected: both read back bit-exact.
- load_start after 37 words, then a full reload with value 500+k. Expected: mem_valid 0 throughout; afterwards column 0 row 0 = 500; a simultaneous final-word/load_start case leaves mem_valid=0.
- Reset asserted mid-load at word 60. Expected: load_ready, mem_valid, load_done and weightMem all 0 asynchronously; a fresh full load then succeeds.
- Read sweep colAddress 0→7 on consecutive cycles. Expected: the column for each address appears exactly 1 cycle later, with no bubbles.
